// File: rtl/fsm_seq_pkg.sv
// fsm_seq_pkg: shared types, constants and width helper for the fsm_seq sequencer
package fsm_seq_pkg;
  localparam int ST_FIRST = 0;
  typedef logic [3:0] y_t;
  typedef enum logic [1:0] {TR_HOLD, TR_STEP, TR_WRAP, TR_FIRST} tr_e;
  function automatic int state_w(input int n);
    return n > 2 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/fsm_seq_if.sv
// fsm_seq_if: control, operand and result bundle of the fsm_seq sequencer
interface fsm_seq_if #(
  parameter int NUM_STATES = 9,
  parameter int WIDTH = 4
);
  localparam int SW = fsm_seq_pkg::state_w(NUM_STATES);
  logic en;
  logic restart;
  logic [NUM_STATES-1:0] adv;
  logic [NUM_STATES*WIDTH-1:0] c;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] y;
  logic [SW-1:0] state;
  logic done;
  modport master (output en, restart, adv, c, a, input y, state, done);
  modport slave (input en, restart, adv, c, a, output y, state, done);
endinterface

// File: rtl/fsm_seq_next.sv
// fsm_seq_next: combinational next-state and done-set decode for fsm_seq
module fsm_seq_next import fsm_seq_pkg::*; #(
  parameter int NUM_STATES = 9,
  parameter int WRAP = 1
) (
  input  logic [state_w(NUM_STATES)-1:0] state,
  input  logic [NUM_STATES-1:0] adv,
  input  logic en,
  input  logic restart,
  output logic [state_w(NUM_STATES)-1:0] state_nxt,
  output logic done_set
);
  localparam int SW = state_w(NUM_STATES);
  localparam logic [SW-1:0] LAST = SW'(NUM_STATES - 1);
  tr_e tr;
  // encodings above LAST are unreachable and fall back to the first state
  always_comb begin
    tr = TR_HOLD;
    if (restart || (en && state > LAST)) tr = TR_FIRST;
    else if (en && adv[state]) tr = state != LAST ? TR_STEP : WRAP != 0 ? TR_WRAP : TR_HOLD;
    state_nxt = tr == TR_STEP ? state + 1'b1 : tr == TR_HOLD ? state : SW'(ST_FIRST);
    done_set = WRAP != 0 ? tr == TR_WRAP : tr != TR_FIRST && en && state_nxt == LAST;
  end
endmodule

// File: rtl/fsm_seq.sv
// fsm_seq: linear sequencer FSM with a per-state output accumulator
// Define FSM_SEQ_SATURATE_EN to clamp y at all-ones instead of wrapping modulo 2^WIDTH.
module fsm_seq import fsm_seq_pkg::*; #(
  parameter int NUM_STATES = 9,
  parameter int WIDTH = $bits(y_t),
  parameter int WRAP = 1
) (
  input logic clock,
  input logic reset,
  fsm_seq_if.slave bus
);
  localparam int SW = state_w(NUM_STATES);
  logic [SW-1:0] state_q, state_d;
  logic [WIDTH-1:0] y_q, cur_c, sum;
  logic done_q, done_set;
  fsm_seq_next #(.NUM_STATES(NUM_STATES), .WRAP(WRAP)) u_next (
    .state(state_q),
    .adv(bus.adv),
    .en(bus.en),
    .restart(bus.restart),
    .state_nxt(state_d),
    .done_set(done_set)
  );
  assign cur_c = int'(state_q) < NUM_STATES ? bus.c[int'(state_q)*WIDTH +: WIDTH] : '0;
`ifdef FSM_SEQ_SATURATE_EN
  logic [WIDTH:0] wide;
  assign wide = {1'b0, bus.a} + {1'b0, cur_c};
  assign sum = wide[WIDTH] ? '1 : wide[WIDTH-1:0];
`else
  assign sum = bus.a + cur_c;
`endif
  // a wrap-mode done is a single-cycle pulse; otherwise it is sticky until restart
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= '0;
      y_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (bus.en) y_q <= sum;
      done_q <= WRAP != 0 ? done_set : !bus.restart && (done_q || done_set);
    end
  end
  assign bus.y = y_q;
  assign bus.state = state_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_fsm_seq.sv
// tb_fsm_seq: directed and randomized checks of fsm_seq (wrap and stop variants) against a behavioural model
module tb_fsm_seq;
  import fsm_seq_pkg::*;
  localparam int N = 9;
  localparam int W = 4;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  logic en_i = 1'b1;
  logic rs_i = 1'b0;
  logic [N-1:0] adv_i = '1;
  int cv[N];
  int ms[2];
  int my[2];
  int md[2];

  always #5 clock = ~clock;

  fsm_seq_if #(.NUM_STATES(N), .WIDTH(W)) bw ();
  fsm_seq_if #(.NUM_STATES(N), .WIDTH(W)) bs ();
  fsm_seq #(.NUM_STATES(N), .WIDTH(W), .WRAP(1)) u_w (.clock(clock), .reset(reset), .bus(bw.slave));
  fsm_seq #(.NUM_STATES(N), .WIDTH(W), .WRAP(0)) u_s (.clock(clock), .reset(reset), .bus(bs.slave));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int add(input int a, input int c);
`ifdef FSM_SEQ_SATURATE_EN
    return a + c > 2**W - 1 ? 2**W - 1 : a + c;
`else
    return (a + c) % (2**W);
`endif
  endfunction

  // one clock edge of the sequencer, expressed as plain integer rules
  task automatic model(input int i, input bit wrap);
    int old;
    old = ms[i];
    if (!reset) begin
      ms[i] = 0;
      my[i] = 0;
      md[i] = 0;
      return;
    end
    if (en_i) my[i] = add(my[i], cv[old]);
    if (rs_i) ms[i] = 0;
    else if (en_i && adv_i[old]) ms[i] = old < N - 1 ? old + 1 : wrap ? 0 : old;
    if (wrap) md[i] = (en_i && !rs_i && adv_i[old] && old == N - 1) ? 1 : 0;
    else md[i] = (!rs_i && (md[i] != 0 || ms[i] == N - 1)) ? 1 : 0;
  endtask

  task automatic drive();
    bw.en = en_i;
    bs.en = en_i;
    bw.restart = rs_i;
    bs.restart = rs_i;
    bw.adv = adv_i;
    bs.adv = adv_i;
    for (int k = 0; k < N; k++) begin
      bw.c[k*W +: W] = W'(cv[k]);
      bs.c[k*W +: W] = W'(cv[k]);
    end
    bw.a = W'(my[0]);
    bs.a = W'(my[1]);
  endtask

  task automatic tick();
    drive();
    @(posedge clock);
    model(0, 1'b1);
    model(1, 1'b0);
    @(negedge clock);
    chk("wrap_y", 32'(bw.y), 32'(my[0]));
    chk("wrap_state", 32'(bw.state), 32'(ms[0]));
    chk("wrap_done", 32'(bw.done), 32'(md[0]));
    chk("stop_y", 32'(bs.y), 32'(my[1]));
    chk("stop_state", 32'(bs.state), 32'(ms[1]));
    chk("stop_done", 32'(bs.done), 32'(md[1]));
  endtask

  initial begin
    int y1[10];
    int pulses;
    int saved_y;
`ifdef FSM_SEQ_SATURATE_EN
    y1 = '{0, 1, 3, 6, 10, 15, 15, 15, 15, 15};
`else
    y1 = '{0, 1, 3, 6, 10, 15, 5, 12, 4, 4};
`endif
    for (int k = 0; k < N; k++) cv[k] = k;
    ms = '{0, 0};
    my = '{0, 0};
    md = '{0, 0};
    drive();
    @(negedge clock);
    repeat (16) tick();
    reset = 1'b1;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("s1_y", 32'(bw.y), 32'(y1[k]));
      chk("s1_state", 32'(bw.state), 32'((k + 1) % N));
      pulses += int'(bw.done);
    end
    chk("s1_pulses", 32'(pulses), 32'd1);
    repeat (2) tick();
    chk("s3_state", 32'(bs.state), 32'd8);
    chk("s3_done", 32'(bs.done), 32'd1);
    rs_i = 1'b1;
    tick();
    rs_i = 1'b0;
    adv_i[3] = 1'b0;
    pulses = 0;
    repeat (10) begin
      tick();
      pulses += int'(bw.done);
    end
    chk("s4_state", 32'(bw.state), 32'd3);
    chk("s4_pulses", 32'(pulses), 32'd0);
    adv_i = '1;
    rs_i = 1'b1;
    tick();
    rs_i = 1'b0;
    repeat (4) tick();
    chk("s5_state", 32'(bw.state), 32'd4);
    saved_y = my[0];
    en_i = 1'b0;
    repeat (5) tick();
    chk("s5_frozen_y", 32'(bw.y), 32'(saved_y));
    chk("s5_frozen_state", 32'(bw.state), 32'd4);
    en_i = 1'b1;
    tick();
    chk("s5_resume_state", 32'(bw.state), 32'd5);
    tick();
    saved_y = my[0];
    rs_i = 1'b1;
    tick();
    rs_i = 1'b0;
    chk("s6_state", 32'(bw.state), 32'd0);
    chk("s6_y", 32'(bw.y), 32'(add(saved_y, 6)));
    repeat (6) tick();
    rs_i = 1'b1;
    reset = 1'b0;
    tick();
    chk("s6_rst_y", 32'(bw.y), 32'd0);
    chk("s6_rst_state", 32'(bw.state), 32'd0);
    reset = 1'b1;
    rs_i = 1'b0;
    for (int t = 0; t < 400; t++) begin
      en_i = $urandom_range(0, 9) != 0;
      rs_i = $urandom_range(0, 19) == 0;
      adv_i = $urandom_range(0, 3) == 0 ? N'($urandom) : '1;
      reset = $urandom_range(0, 49) != 0;
      if (t % 50 == 0) for (int k = 0; k < N; k++) cv[k] = $urandom_range(0, 2**W - 1);
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
